// File: rtl/watch_disp_scan.sv
// Six-digit multiplexed 7-segment scanner for the watch time digits, with a
// per-frame snapshot of the digits and a blinking colon.
// Optional: `define LEAD_ZERO_BLANK_EN blanks a zero hours-tens digit.
module watch_disp_scan #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_1,
  input  logic [2:0] sec_10,
  input  logic [3:0] min_1,
  input  logic [2:0] min_10,
  input  logic [3:0] hour_1,
  input  logic [1:0] hour_10,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned LAST_I = 5;

  typedef struct packed {
    logic [1:0] hour_10;
    logic [3:0] hour_1;
    logic [2:0] min_10;
    logic [3:0] min_1;
    logic [2:0] sec_10;
    logic [3:0] sec_1;
  } digits_t;

  logic [CNT_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;
  digits_t          cur_c;
  digits_t          samp;
  digits_t          shadow;
  logic             pend;

  logic             tick_c;
  logic             frame_c;
  logic             stable_c;
  logic             blank_c;
  logic [3:0]       digit_c;
  logic [5:0]       an_c;
  logic [6:0]       seg_c;
  logic             dp_c;

  assign cur_c    = {hour_10, hour_1, min_10, min_1, sec_10, sec_1};
  assign tick_c   = (div_cnt == CNT_W'(SCAN_DIV - 1));
  assign frame_c  = tick_c && (idx == IDX_W'(LAST_I));
  assign stable_c = (samp == cur_c);
  assign blank_c  = (BLANK_CYC != 0) && (div_cnt < CNT_W'(BLANK_CYC));

  // Slot prescaler and digit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_W'(LAST_I)) ? '0 : idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // Inputs are ripple-clocked: only load the shadow when two samples agree
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp   <= '0;
      shadow <= '0;
      pend   <= 1'b0;
    end else begin
      samp <= cur_c;
      if (pend) begin
        if (stable_c) begin
          shadow <= cur_c;
          pend   <= 1'b0;
        end
      end else if (frame_c) begin
        if (stable_c) shadow <= cur_c;
        else          pend   <= 1'b1;
      end
    end
  end

  // Digit select, decode, colon and anode drive
  always_comb begin
    digit_c = 4'hF;
    seg_c   = 7'h7F;
    dp_c    = 1'b1;
    an_c    = 6'h3F;
    case (idx)
      3'd0:    digit_c = shadow.sec_1;
      3'd1:    digit_c = 4'(shadow.sec_10);
      3'd2:    digit_c = shadow.min_1;
      3'd3:    digit_c = 4'(shadow.min_10);
      3'd4:    digit_c = shadow.hour_1;
      3'd5:    digit_c = 4'(shadow.hour_10);
      default: digit_c = 4'hF;
    endcase
    case (digit_c)
      4'd0:    seg_c = 7'h40;
      4'd1:    seg_c = 7'h79;
      4'd2:    seg_c = 7'h24;
      4'd3:    seg_c = 7'h30;
      4'd4:    seg_c = 7'h19;
      4'd5:    seg_c = 7'h12;
      4'd6:    seg_c = 7'h02;
      4'd7:    seg_c = 7'h78;
      4'd8:    seg_c = 7'h00;
      4'd9:    seg_c = 7'h10;
      default: seg_c = 7'h7F;
    endcase
    if (((idx == 3'd2) || (idx == 3'd4)) && !shadow.sec_1[0]) dp_c = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
    if ((idx == IDX_W'(LAST_I)) && (shadow.hour_10 == 2'd0)) begin
      seg_c = 7'h7F;
      dp_c  = 1'b1;
    end
`endif
    if (!blank_c) an_c = ~(6'b1 << idx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 6'h3F;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_c;
      seg <= seg_c;
      dp  <= dp_c;
    end
  end

endmodule

// File: tb/tb_watch_disp_scan.sv
// Directed bench for watch_disp_scan with an 8-cycle slot and 2-cycle blanking.
module tb_watch_disp_scan;

  logic       clk;
  logic       rst;
  logic [3:0] sec_1;
  logic [2:0] sec_10;
  logic [3:0] min_1;
  logic [2:0] min_10;
  logic [3:0] hour_1;
  logic [1:0] hour_10;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int total;
  int bad;
  int cyc;

  watch_disp_scan #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst),
    .sec_1(sec_1), .sec_10(sec_10), .min_1(min_1), .min_10(min_10),
    .hour_1(hour_1), .hour_10(hour_10),
    .an(an), .seg(seg), .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle; cyc counts edges since the last reset release
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic goto(input int k);
    while (cyc < k) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    {sec_1, sec_10, min_1, min_10, hour_1, hour_10} = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (an !== 6'h3F) begin bad++; $display("FAIL rst_an: got %h expected 3f", an); end
    total++; if (seg !== 7'h7F) begin bad++; $display("FAIL rst_seg: got %h expected 7f", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL rst_dp: got %b expected 1", dp); end
    rst = 1'b1;
    cyc = 0;
    step();
    total++; if (an !== 6'h3F) begin bad++; $display("FAIL blank1_an: got %h expected 3f", an); end
    step();
    total++; if (an !== 6'h3F) begin bad++; $display("FAIL blank2_an: got %h expected 3f", an); end
    step();
    total++; if (an !== 6'h3E) begin bad++; $display("FAIL first_an: got %h expected 3e", an); end
    total++; if (seg !== 7'h40) begin bad++; $display("FAIL first_seg: got %h expected 40", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL first_dp: got %b expected 1", dp); end
    goto(8);
    total++; if (an !== 6'h3E) begin bad++; $display("FAIL slot0_end_an: got %h expected 3e", an); end
    goto(10);
    total++; if (an !== 6'h3F) begin bad++; $display("FAIL slot1_blank_an: got %h expected 3f", an); end
    goto(11);
    total++; if (an !== 6'h3D) begin bad++; $display("FAIL slot1_an: got %h expected 3d", an); end
  endtask

  task automatic test_steady();
    logic [6:0] es [6];
    es = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    hour_10 = 2'd1; hour_1 = 4'd2; min_10 = 3'd3; min_1 = 4'd4; sec_10 = 3'd5; sec_1 = 4'd6;
    for (int i = 0; i < 6; i++) begin
      logic [5:0] ea;
      logic       ed;
      ea = ~(6'b1 << i);
      ed = (i == 2 || i == 4) ? 1'b0 : 1'b1;
      goto(48 + 8 * i + 1);
      total++; if (an !== 6'h3F) begin bad++; $display("FAIL steady_blank%0d: got %h expected 3f", i, an); end
      goto(48 + 8 * i + 3);
      total++; if (an !== ea) begin bad++; $display("FAIL steady_an%0d: got %h expected %h", i, an, ea); end
      total++; if (seg !== es[i]) begin bad++; $display("FAIL steady_seg%0d: got %h expected %h", i, seg, es[i]); end
      total++; if (dp !== ed) begin bad++; $display("FAIL steady_dp%0d: got %b expected %b", i, dp, ed); end
    end
  endtask

  task automatic test_colon();
    sec_1 = 4'd7;
    for (int i = 0; i < 6; i++) begin
      goto(96 + 8 * i + 3);
      total++; if (dp !== 1'b1) begin bad++; $display("FAIL odd_dp%0d: got %b expected 1", i, dp); end
      if (i == 0) begin
        total++; if (seg !== 7'h78) begin bad++; $display("FAIL odd_seg0: got %h expected 78", seg); end
      end
    end
    sec_1 = 4'd8;
    for (int i = 0; i < 6; i++) begin
      logic ed;
      ed = (i == 2 || i == 4) ? 1'b0 : 1'b1;
      goto(144 + 8 * i + 3);
      total++; if (dp !== ed) begin bad++; $display("FAIL even_dp%0d: got %b expected %b", i, dp, ed); end
      if (i == 0) begin
        total++; if (seg !== 7'h00) begin bad++; $display("FAIL even_seg0: got %h expected 00", seg); end
      end
    end
  endtask

  task automatic test_deferral();
    goto(191);
    sec_10 = 3'd2;
    step();
    total++; if (dut.pend !== 1'b1) begin bad++; $display("FAIL defer_pend_set: got %b expected 1", dut.pend); end
    total++; if (dut.shadow.sec_10 !== 3'd5) begin bad++; $display("FAIL defer_hold: got %0d expected 5", dut.shadow.sec_10); end
    step();
    total++; if (dut.pend !== 1'b0) begin bad++; $display("FAIL defer_pend_clr: got %b expected 0", dut.pend); end
    total++; if (dut.shadow.sec_10 !== 3'd2) begin bad++; $display("FAIL defer_load: got %0d expected 2", dut.shadow.sec_10); end
    goto(195);
    total++; if (seg !== 7'h00) begin bad++; $display("FAIL defer_seg0: got %h expected 00", seg); end
    goto(203);
    total++; if (an !== 6'h3D) begin bad++; $display("FAIL defer_an1: got %h expected 3d", an); end
    total++; if (seg !== 7'h24) begin bad++; $display("FAIL defer_seg1: got %h expected 24", seg); end
  endtask

  task automatic test_invalid_bcd();
    logic [6:0] es [6];
    logic       ed [6];
`ifdef LEAD_ZERO_BLANK_EN
    es = '{7'h00, 7'h24, 7'h7F, 7'h30, 7'h24, 7'h7F};
`else
    es = '{7'h00, 7'h24, 7'h7F, 7'h30, 7'h24, 7'h40};
`endif
    ed = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    goto(235);
    min_1 = 4'hC;
    hour_10 = 2'd0;
    for (int i = 0; i < 6; i++) begin
      logic [5:0] ea;
      ea = ~(6'b1 << i);
      goto(240 + 8 * i + 3);
      total++; if (an !== ea) begin bad++; $display("FAIL bcd_an%0d: got %h expected %h", i, an, ea); end
      total++; if (seg !== es[i]) begin bad++; $display("FAIL bcd_seg%0d: got %h expected %h", i, seg, es[i]); end
      total++; if (dp !== ed[i]) begin bad++; $display("FAIL bcd_dp%0d: got %b expected %b", i, dp, ed[i]); end
    end
  endtask

  task automatic test_mid_reset();
    goto(288 + 24 + 3);
    total++; if (an !== 6'h37) begin bad++; $display("FAIL pre_rst_an: got %h expected 37", an); end
    rst = 1'b0;
    #1;
    total++; if (an !== 6'h3F) begin bad++; $display("FAIL async_an: got %h expected 3f", an); end
    total++; if (seg !== 7'h7F) begin bad++; $display("FAIL async_seg: got %h expected 7f", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL async_dp: got %b expected 1", dp); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    goto(3);
    total++; if (an !== 6'h3E) begin bad++; $display("FAIL restart_an: got %h expected 3e", an); end
    total++; if (seg !== 7'h40) begin bad++; $display("FAIL restart_seg: got %h expected 40", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL restart_dp: got %b expected 1", dp); end
    goto(19);
    total++; if (an !== 6'h3B) begin bad++; $display("FAIL restart_an2: got %h expected 3b", an); end
    total++; if (seg !== 7'h40) begin bad++; $display("FAIL restart_seg2: got %h expected 40", seg); end
    total++; if (dp !== 1'b0) begin bad++; $display("FAIL restart_dp2: got %b expected 0", dp); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    test_reset();
    test_steady();
    test_colon();
    test_deferral();
    test_invalid_bcd();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
